// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and the hazard sequencer (slave).
// The datapath supplies hazard sources and receives stage enables, flushes and counters.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             MemRead_EX;
    logic [4:0]       RD_EX;
    logic [4:0]       RS1_ID;
    logic [4:0]       RS2_ID;
    logic             use_rs1_ID;
    logic             use_rs2_ID;
    logic             branch_taken;
    logic             mem_access_MEM;
    logic             dmem_ready;
    logic             dmem_valid;
    logic             PC_write;
    logic             IF_ID_write;
    logic             ID_EX_write;
    logic             EX_MEM_write;
    logic             MEM_WB_write;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             MEM_WB_bubble;
    logic             bus_error;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output MemRead_EX, RD_EX, RS1_ID, RS2_ID, use_rs1_ID, use_rs2_ID,
               branch_taken, mem_access_MEM, dmem_ready,
        input  dmem_valid, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
               MEM_WB_write, IF_ID_flush, ID_EX_flush, MEM_WB_bubble,
               bus_error, stall_count, flush_count
    );

    modport slave (
        input  MemRead_EX, RD_EX, RS1_ID, RS2_ID, use_rs1_ID, use_rs2_ID,
               branch_taken, mem_access_MEM, dmem_ready,
        output dmem_valid, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
               MEM_WB_write, IF_ID_flush, ID_EX_flush, MEM_WB_bubble,
               bus_error, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage pipeline: load-use, taken-branch and data-memory
// wait/timeout handling, with saturating stall and flush event counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic              bus_error_q;

    logic mem_stall;
    logic lu_hazard;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_fl, id_ex_fl, mem_wb_bub, dmem_req;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mem_stall = bus.mem_access_MEM & ~bus.dmem_ready;
        lu_hazard = bus.MemRead_EX & (bus.RD_EX != 5'd0) &
                    ((bus.use_rs1_ID & (bus.RS1_ID == bus.RD_EX)) |
                     (bus.use_rs2_ID & (bus.RS2_ID == bus.RD_EX)));

        pc_we      = 1'b1;
        if_id_we   = 1'b1;
        id_ex_we   = 1'b1;
        ex_mem_we  = 1'b1;
        mem_wb_we  = 1'b1;
        if_id_fl   = 1'b0;
        id_ex_fl   = 1'b0;
        mem_wb_bub = 1'b0;
        dmem_req   = reset & (state_q != ERROR) & bus.mem_access_MEM;

        // Reset gating is combinational so an aborted access drops dmem_valid at once.
        if (!reset || state_q == ERROR) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if (mem_stall) begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            ex_mem_we  = 1'b0;
            mem_wb_bub = 1'b1;
        end else if (bus.branch_taken) begin
            if_id_fl = 1'b1;
            id_ex_fl = 1'b1;
        end else if (lu_hazard) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_fl = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            bus_error_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    // The first stalled cycle already counts toward the timeout.
                    if (mem_stall) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q     <= ERROR;
                        bus_error_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ERROR:   state_q <= ERROR;
                default: state_q <= RUN;
            endcase

            if (state_q != ERROR && !pc_we && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (state_q != ERROR && bus.branch_taken && !mem_stall && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.dmem_valid    = dmem_req;
    assign bus.PC_write      = pc_we;
    assign bus.IF_ID_write   = if_id_we;
    assign bus.ID_EX_write   = id_ex_we;
    assign bus.EX_MEM_write  = ex_mem_we;
    assign bus.MEM_WB_write  = mem_wb_we;
    assign bus.IF_ID_flush   = if_id_fl;
    assign bus.ID_EX_flush   = id_ex_fl;
    assign bus.MEM_WB_bubble = mem_wb_bub;
    assign bus.bus_error     = bus_error_q;
    assign bus.stall_count   = stall_cnt_q;
    assign bus.flush_count   = flush_cnt_q;
endmodule
